// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory front end.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } mem_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int BE_W = 4;

endpackage

// File: rtl/mem_access_unit_store_lane_gen.sv
// Byte-enable, store-lane replication and alignment check for one access.
module store_lane_gen
   import mem_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [31:0]     wdata,
   output logic [BE_W-1:0] be,
   output logic [31:0]     wdata_rep,
   output logic            misaligned
);

   always_comb begin
      be         = 4'b1111;
      wdata_rep  = wdata;
      misaligned = 1'b0;
      // funct3[2] only selects sign handling downstream; size lives in [1:0]
      case (funct3[1:0])
         F3_B[1:0]: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         F3_H[1:0]: begin
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_rep  = {2{wdata[15:0]}};
            misaligned = addr_lo[0];
         end
         F3_W[1:0]: begin
            misaligned = |addr_lo;
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory front end: issues one handshaked access per
// instruction, stalls until response or timeout, and aligns load data.
//
// state  | meaning
// IDLE   | waiting for an access; misaligned ones are rejected here
// ACCESS | request on the bus, waiting for dmem_ready or timeout
// RESP   | access finished, done pulse, rdata_aligned valid
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] rdata_aligned,
   output logic            misaligned,
   output logic            bus_error,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [BE_W-1:0] dmem_be,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ready
);

   localparam int CW = $clog2(TIMEOUT + 1);

   mem_state_t      state;
   logic [CW-1:0]   tmr;
   logic [XLEN-1:2] addr_hi_q;
   logic [1:0]      addr_lo_q;
   logic [XLEN-1:0] wdata_q;
   logic [BE_W-1:0] be_q;
   logic            we_q;
   logic            berr_q;

   logic [BE_W-1:0] be_c;
   logic [XLEN-1:0] wdata_c;
   logic            mis_c;
   logic            req_c;

   store_lane_gen u_lane (
      .funct3     (funct3),
      .addr_lo    (addr[1:0]),
      .wdata      (wdata),
      .be         (be_c),
      .wdata_rep  (wdata_c),
      .misaligned (mis_c)
   );

   assign req_c = (state == IDLE) && (mem_read || mem_write) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         tmr           <= '0;
         addr_hi_q     <= '0;
         addr_lo_q     <= '0;
         wdata_q       <= '0;
         be_q          <= '0;
         we_q          <= 1'b0;
         berr_q        <= 1'b0;
         rdata_aligned <= '0;
      end else begin
         case (state)
            IDLE: begin
               berr_q <= 1'b0;
               if ((mem_read || mem_write) && !mis_c) begin
                  addr_hi_q <= addr[XLEN-1:2];
                  addr_lo_q <= addr[1:0];
                  wdata_q   <= wdata_c;
                  be_q      <= be_c;
                  we_q      <= mem_write && !mem_read;
                  tmr       <= CW'(TIMEOUT - 1);
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (dmem_ready) begin
                  rdata_aligned <= we_q ? '0 : (dmem_rdata >> {addr_lo_q, 3'b000});
                  state         <= RESP;
               end else if (tmr == '0) begin
                  berr_q        <= 1'b1;
                  rdata_aligned <= '0;
                  state         <= RESP;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            RESP: begin
               berr_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign stall      = (req_c && !mis_c) || (state == ACCESS);
   assign misaligned = req_c && mis_c;
   assign done       = misaligned || (state == RESP);
   assign bus_error  = berr_q;
   assign dmem_req   = (state == ACCESS);
   assign dmem_we    = (state == ACCESS) && we_q;
   assign dmem_be    = be_q;
   assign dmem_addr  = {addr_hi_q, 2'b00};
   assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT=4.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        stall, done, misaligned, bus_error;
   logic [31:0] rdata_aligned;
   logic        dmem_req, dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ready;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.XLEN(32), .TIMEOUT(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .funct3        (funct3),
      .addr          (addr),
      .wdata         (wdata),
      .stall         (stall),
      .done          (done),
      .rdata_aligned (rdata_aligned),
      .misaligned    (misaligned),
      .bus_error     (bus_error),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_be       (dmem_be),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_rdata    (dmem_rdata),
      .dmem_ready    (dmem_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then settle before checks.
   task automatic cyc(input logic rst, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy, input logic [31:0] rdat);
      @(negedge clk);
      reset = rst; mem_read = rd; mem_write = wr; funct3 = f3;
      addr = a; wdata = wd; dmem_ready = rdy; dmem_rdata = rdat;
      #1;
   endtask

   task automatic idle_cyc();
      cyc(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      int stall_n;
      int req_n;
      int budget;

      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
      addr = '0; wdata = '0; dmem_ready = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      idle_cyc();
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_req", {31'b0, dmem_req}, 32'h0);
      chk("rst_rdata", rdata_aligned, 32'h0);
      chk("rst_be", {28'b0, dmem_be}, 32'h0);

      // SB to byte 3, ready in first ACCESS cycle
      cyc(1'b0, 1'b0, 1'b1, 3'b000, 32'h1003, 32'hAABBCCDD, 1'b0, 32'h0);
      chk("sb_c1_stall", {31'b0, stall}, 32'h1);
      chk("sb_c1_req", {31'b0, dmem_req}, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'h0);
      chk("sb_c2_stall", {31'b0, stall}, 32'h1);
      chk("sb_c2_req", {31'b0, dmem_req}, 32'h1);
      chk("sb_addr", dmem_addr, 32'h1000);
      chk("sb_be", {28'b0, dmem_be}, 32'h8);
      chk("sb_wdata", dmem_wdata, 32'hDDDDDDDD);
      chk("sb_we", {31'b0, dmem_we}, 32'h1);
      idle_cyc();
      chk("sb_c3_done", {31'b0, done}, 32'h1);
      chk("sb_c3_stall", {31'b0, stall}, 32'h0);
      chk("sb_c3_req", {31'b0, dmem_req}, 32'h0);

      // LH at 0x2002, three wait cycles, mem_read held through RESP
      stall_n = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, (i == 4), 32'h87654321);
         if (stall) stall_n++;
         if (i == 2) chk("lh_be", {28'b0, dmem_be}, 32'hC);
      end
      cyc(1'b0, 1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 1'b0, 32'h0);
      chk("lh_stall_cycles", stall_n, 32'd5);
      chk("lh_done", {31'b0, done}, 32'h1);
      chk("lh_resp_stall", {31'b0, stall}, 32'h0);
      chk("lh_rdata", rdata_aligned, 32'h00008765);
      idle_cyc();
      chk("lh_done_once", {31'b0, done}, 32'h0);
      chk("lh_no_reissue", {31'b0, dmem_req}, 32'h0);

      // Misaligned LW
      cyc(1'b0, 1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 1'b0, 32'h0);
      chk("mis_flag", {31'b0, misaligned}, 32'h1);
      chk("mis_done", {31'b0, done}, 32'h1);
      chk("mis_stall", {31'b0, stall}, 32'h0);
      chk("mis_req", {31'b0, dmem_req}, 32'h0);
      idle_cyc();
      chk("mis_req_after", {31'b0, dmem_req}, 32'h0);
      chk("mis_pulse", {31'b0, misaligned}, 32'h0);

      // LW with no ready: timeout after 4 request cycles
      cyc(1'b0, 1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 1'b0, 32'h0);
      req_n = 0;
      budget = 0;
      do begin
         idle_cyc();
         if (dmem_req) req_n++;
         budget++;
      end while (!done && budget < 20);
      chk("to_bounded", {31'b0, done}, 32'h1);
      chk("to_req_cycles", req_n, 32'd4);
      chk("to_bus_error", {31'b0, bus_error}, 32'h1);
      chk("to_rdata", rdata_aligned, 32'h0);
      idle_cyc();
      chk("to_berr_pulse", {31'b0, bus_error}, 32'h0);
      chk("to_idle", {31'b0, stall | dmem_req}, 32'h0);

      // Read and write both set: behaves as a load
      cyc(1'b0, 1'b1, 1'b1, 3'b010, 32'h60, 32'hFFFFFFFF, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'h12345678);
      chk("rw_we", {31'b0, dmem_we}, 32'h0);
      chk("rw_be", {28'b0, dmem_be}, 32'hF);
      chk("rw_addr", dmem_addr, 32'h60);
      idle_cyc();
      chk("rw_rdata", rdata_aligned, 32'h12345678);

      // Reset in the second ACCESS cycle
      cyc(1'b0, 1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 1'b0, 32'h0);
      idle_cyc();
      cyc(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("rst_mid_req", {31'b0, dmem_req}, 32'h1);
      idle_cyc();
      chk("rst_mid_ctl", {26'b0, stall, done, misaligned, bus_error, dmem_req, dmem_we}, 32'h0);
      chk("rst_mid_be", {28'b0, dmem_be}, 32'h0);
      chk("rst_mid_addr", dmem_addr, 32'h0);
      chk("rst_mid_wdata", dmem_wdata, 32'h0);
      chk("rst_mid_rdata", rdata_aligned, 32'h0);

      // LW 0x40 after reset completes normally
      cyc(1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h0);
      chk("lw40_stall", {31'b0, stall}, 32'h1);
      cyc(1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 32'hCAFEF00D);
      chk("lw40_addr", dmem_addr, 32'h40);
      chk("lw40_req", {31'b0, dmem_req}, 32'h1);
      idle_cyc();
      chk("lw40_done", {31'b0, done}, 32'h1);
      chk("lw40_rdata", rdata_aligned, 32'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory front end. Sits directly upstream of the load-extension stage (Loadcontrol) and feeds it.
- Takes the EX/MEM access (address, store data, funct3, MemRead/MemWrite) and drives a handshaked data memory with byte enables and lane-replicated store data.
- Stalls the pipeline until the memory responds, then hands the load word to the extension stage, shifted so the addressed byte/half sits in bits [7:0]/[15:0].
- Flags misaligned accesses and memory timeouts.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT, 64, maximum cycles waiting for dmem_ready before bus_error. Must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  load request from EX/MEM.
- mem_write  in  1  store request from EX/MEM.
- funct3  in  3  access size/sign; same encoding as the load-extension stage.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- stall  out  1  hold IF/ID/EX/MEM registers.
- done  out  1  one-cycle pulse: access finished.
- rdata_aligned  out  32  load word shifted right by 8*addr[1:0], to Loadcontrol InputData.
- misaligned  out  1  one-cycle pulse, access suppressed.
- bus_error  out  1  one-cycle pulse, timeout.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_be  out  4  byte enables.
- dmem_addr  out  32  word address, {addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data, valid when dmem_ready=1.
- dmem_ready  in  1  memory completes the request this cycle.

Behaviour:
- Clocking and reset: one clock (clk). reset is synchronous and active-high.
  - reset=1 at an edge puts the FSM in IDLE and clears the timeout counter, rdata_aligned and all latched request fields.
  - All outputs read 0 after reset, including during an in-flight access; dmem_req drops on the next edge.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - An access is present when mem_read|mem_write.
  - Alignment check: half (funct3[1:0]=01) needs addr[0]=0; word (10) needs addr[1:0]=00.
  - Misaligned access: misaligned=1 and done=1 combinationally, stall=0, no dmem_req, stay in IDLE.
  - Aligned access: stall=1 combinationally. Latch addr, funct3, we=mem_write&~mem_read, be and wdata. Go to ACCESS.
- ACCESS:
  - dmem_req=1 and stall=1. dmem_addr, dmem_we, dmem_be and dmem_wdata are held stable from the latches.
  - dmem_ready=1: capture dmem_rdata >> (8*addr[1:0]), zero-filled; 0 for stores. Go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without ready: bus_error=1, rdata_aligned=0, go to RESP.
- RESP:
  - done=1, stall=0, dmem_req=0. rdata_aligned is valid and held until the next capture.
  - Next state is IDLE. mem_read/mem_write are ignored this cycle, because the same instruction is still presented.
- Latency: with ready in the first ACCESS cycle, the stall lasts 2 cycles (IDLE, ACCESS) and done comes on cycle 3.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<{addr[1],1'b0}.
  - word, and undefined funct3 (011, 110, 111): 4'b1111. Loads use the same be.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- mem_read and mem_write both set: treated as a read, and dmem_we=0.
- dmem_ready while not in ACCESS is ignored.
- Inputs may change during ACCESS; only the latched values drive memory.
- The counter is cleared on entry to ACCESS.

Decomposition:
- Package mem_pkg holds:
  - state enum mem_state_t {IDLE, ACCESS, RESP}.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - localparam BE_W=4.
- Sub-module store_lane_gen (combinational): funct3, addr[1:0], wdata -> be, replicated wdata, misaligned.

Test Plan:
- SB addr=0x1003 wdata=0xAABBCCDD, ready in 1st ACCESS cycle -> dmem_addr=0x1000, be=1000, dmem_wdata=0xDDDDDDDD, we=1; stall high 2 cycles; done on cycle 3.
- LH funct3=001 addr=0x2002, dmem_rdata=0x8765_4321, ready after 3 wait cycles -> be=1100, stall held 5 cycles, rdata_aligned=0x0000_8765, done pulse once.
- LW addr=0x3001 -> misaligned=1, done=1 same cycle, stall=0, dmem_req never asserts.
- LW with dmem_ready held 0, TIMEOUT=4 -> dmem_req high exactly 4 cycles, then bus_error=1, rdata_aligned=0, done=1, back to IDLE.
- reset=1 asserted in the 2nd ACCESS cycle -> next cycle all outputs 0, FSM in IDLE; a following LW 0x40 completes normally.
- mem_read=mem_write=1, funct3=010 -> dmem_we=0, be=1111, treated as a load.
